// File: rtl/muldiv_unit_if.sv
// Request/result bundle between the pipeline and the iterative mul/div unit.
// master drives start/op/a/b/flush; slave returns busy/done/writes/results.
interface muldiv_unit_if;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        flush;
  logic        busy;
  logic        done;
  logic        hiwrite;
  logic        lowrite;
  logic [31:0] hi_out;
  logic [31:0] lo_out;

  modport master (
    output start, op, a, b, flush,
    input  busy, done, hiwrite, lowrite, hi_out, lo_out
  );

  modport slave (
    input  start, op, a, b, flush,
    output busy, done, hiwrite, lowrite, hi_out, lo_out
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative 32x32 MULT/MULTU/DIV/DIVU unit, 33-cycle latency, HI/LO writeback.
// Ports: clk, reset (sync, active-high), bus (muldiv_unit_if.slave).
module muldiv_unit (
  input logic          clk,
  input logic          reset,
  muldiv_unit_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t      state;
  logic [5:0]  cnt;
  logic [1:0]  opr;
  logic [31:0] d;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        sa;
  logic        sb;
  logic        bz;
  logic        busy_q;
  logic        done_q;
  logic [31:0] hi_q;
  logic [31:0] lo_q;

  logic        sgn_in;
  logic        is_div;
  logic        sgn;
  logic [32:0] mul_sum;
  logic [32:0] div_sh;
  logic [32:0] div_t;
  logic [31:0] nhi;
  logic [31:0] nlo;
  logic [63:0] prod;
  logic [31:0] rhi;
  logic [31:0] rlo;

  assign sgn_in = ~bus.op[0];
  assign is_div = opr[1];
  assign sgn    = ~opr[0];

  // Multiply: {hi,lo} shifts right, lo holds the multiplier bits.
  // Divide: hi is the partial remainder, lo shifts dividend out and
  // quotient bits in.
  always_comb begin
    mul_sum = {1'b0, hi} + (lo[0] ? {1'b0, d} : 33'd0);
    div_sh  = {hi, lo[31]};
    div_t   = div_sh - {1'b0, d};
    if (is_div) begin
      if (!div_t[32]) begin
        nhi = div_t[31:0];
        nlo = {lo[30:0], 1'b1};
      end else begin
        nhi = div_sh[31:0];
        nlo = {lo[30:0], 1'b0};
      end
    end else begin
      nhi = mul_sum[32:1];
      nlo = {mul_sum[0], lo[31:1]};
    end
    prod = {nhi, nlo};
    if (sgn && (sa ^ sb)) begin
      prod = -prod;
    end
    rhi = prod[63:32];
    rlo = prod[31:0];
    if (is_div) begin
      rlo = (sgn && (sa ^ sb)) ? -nlo : nlo;
      // zero divisor leaves |a| in hi; re-signing restores a
      rhi = (sgn && sa) ? -nhi : nhi;
      if (bz) begin
        rlo = '1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      opr    <= '0;
      d      <= '0;
      hi     <= '0;
      lo     <= '0;
      sa     <= 1'b0;
      sb     <= 1'b0;
      bz     <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.start && !bus.flush) begin
            state  <= CALC;
            busy_q <= 1'b1;
            cnt    <= '0;
            opr    <= bus.op;
            sa     <= sgn_in & bus.a[31];
            sb     <= sgn_in & bus.b[31];
            bz     <= (bus.b == 32'd0);
            hi     <= '0;
            lo     <= (sgn_in & bus.a[31]) ? -bus.a : bus.a;
            d      <= (sgn_in & bus.b[31]) ? -bus.b : bus.b;
          end
        end
        CALC: begin
          if (bus.flush) begin
            state  <= IDLE;
            busy_q <= 1'b0;
            cnt    <= '0;
          end else begin
            hi  <= nhi;
            lo  <= nlo;
            cnt <= cnt + 6'd1;
            if (cnt == 6'd31) begin
              state  <= DONE;
              cnt    <= '0;
              done_q <= 1'b1;
              hi_q   <= rhi;
              lo_q   <= rlo;
            end
          end
        end
        DONE: begin
          state  <= IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.hiwrite = done_q;
  assign bus.lowrite = done_q;
  assign bus.hi_out  = hi_q;
  assign bus.lo_out  = lo_q;
endmodule
